// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard and forwarding controller for a 5-stage MIPS pipeline.
//               Keeps its own shadow of EX/MEM/WB and drives stall, flush and
//               EX/ID forward selects.
//               Optional stall/flush counters are enabled by HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_branch,
    input  logic              branch_taken,
    input  logic              jump,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              nop_mux,
    output logic              if_flush,
    output logic [1:0]        fwd_ex_a,
    output logic [1:0]        fwd_ex_b,
    output logic [1:0]        fwd_id_a,
    output logic [1:0]        fwd_id_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0]        c_FWD_REG  = 2'b00;
    localparam logic [1:0]        c_FWD_MEM  = 2'b10;
    localparam logic [1:0]        c_FWD_WB   = 2'b01;
    localparam logic [REG_AW-1:0] c_ZERO_REG = '0;

    typedef struct packed {
        logic              we;
        logic              ld;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } shadow_t;

    localparam shadow_t c_BUBBLE = '0;

    shadow_t r_ex;
    shadow_t r_mem;
    shadow_t r_wb;
    shadow_t w_id_entry;

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_load_use;
    logic w_br_alu;
    logic w_br_load;
    logic w_stall;
    logic w_flush;
    logic w_unused_ok;

    // Register 0 is hard-wired, so a rd=0 producer can never be a dependency.
    function automatic logic f_match(
        input logic              used,
        input shadow_t           stg,
        input logic [REG_AW-1:0] src
    );
        return used && stg.we && (stg.rd != c_ZERO_REG) && (stg.rd == src);
    endfunction

    function automatic logic [1:0] f_fwd(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input shadow_t           mem,
        input shadow_t           wb
    );
        if (f_match(used, mem, src) && !mem.ld) begin
            return c_FWD_MEM;
        end else if (f_match(used, wb, src)) begin
            return c_FWD_WB;
        end
        return c_FWD_REG;
    endfunction

    assign w_id_entry = {id_reg_write, id_mem_read, id_rd, id_rs, id_rt};

    assign w_ex_hit   = f_match(id_use_rs, r_ex, id_rs)  | f_match(id_use_rt, r_ex, id_rt);
    assign w_mem_hit  = f_match(id_use_rs, r_mem, id_rs) | f_match(id_use_rt, r_mem, id_rt);

    assign w_load_use = r_ex.ld & w_ex_hit;
    assign w_br_alu   = id_branch & ~r_ex.ld & w_ex_hit;
    assign w_br_load  = id_branch & r_mem.ld & w_mem_hit;
    assign w_stall    = w_load_use | w_br_alu | w_br_load;

    // A stalled branch is not yet resolved, so its flush waits for the retry.
    assign w_flush    = (branch_taken | jump) & ~w_stall;

    assign pc_write    = ~w_stall;
    assign if_id_write = ~w_stall;
    assign nop_mux     = w_stall;
    assign if_flush    = w_flush;

    // The EX instruction's own use flags are not tracked; a spurious select on an unused operand is harmless.
    assign fwd_ex_a = f_fwd(1'b1, r_ex.rs, r_mem, r_wb);
    assign fwd_ex_b = f_fwd(1'b1, r_ex.rt, r_mem, r_wb);
    assign fwd_id_a = f_fwd(id_use_rs, id_rs, r_mem, r_wb);
    assign fwd_id_b = f_fwd(id_use_rt, id_rt, r_mem, r_wb);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex  <= c_BUBBLE;
            r_mem <= c_BUBBLE;
            r_wb  <= c_BUBBLE;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_stall ? c_BUBBLE : w_id_entry;
        end
    end

    // Source fields of the later stages are carried only to mirror the pipeline.
    assign w_unused_ok = ^{r_mem.rs, r_mem.rt, r_wb.ld, r_wb.rs, r_wb.rt};

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl driven by directed
//               instruction sequences with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_REG_AW = 5;
    localparam int c_CNT_W  = 32;
`ifdef HAZARD_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [c_REG_AW-1:0] id_rs, id_rt, id_rd;
    logic                id_use_rs, id_use_rt;
    logic                id_reg_write, id_mem_read, id_branch;
    logic                branch_taken, jump;
    logic                pc_write, if_id_write, nop_mux, if_flush;
    logic [1:0]          fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b;
    logic [c_CNT_W-1:0]  stall_cnt, flush_cnt;

    hazard_ctrl #(
        .REG_AW (c_REG_AW),
        .CNT_W  (c_CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_branch    (id_branch),
        .branch_taken (branch_taken),
        .jump         (jump),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .nop_mux      (nop_mux),
        .if_flush     (if_flush),
        .fwd_ex_a     (fwd_ex_a),
        .fwd_ex_b     (fwd_ex_b),
        .fwd_id_a     (fwd_id_a),
        .fwd_id_b     (fwd_id_b),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    // ctrl = {pc_write, if_id_write, nop_mux, if_flush}; fwd = {ex_a, ex_b, id_a, id_b}
    typedef struct packed {
        logic [31:0]        id;
        logic [3:0]         ctrl;
        logic [7:0]         fwd;
        logic [c_CNT_W-1:0] sc;
        logic [c_CNT_W-1:0] fc;
    } exp_t;

    exp_t               sb[$];
    int                 n_total = 0;
    int                 n_pass  = 0;
    logic [c_CNT_W-1:0] m_sc = '0;
    logic [c_CNT_W-1:0] m_fc = '0;

    task automatic check(input string nm, input logic [31:0] id, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ctrl", e.id, {28'd0, pc_write, if_id_write, nop_mux, if_flush}, {28'd0, e.ctrl});
            check("fwd", e.id, {24'd0, fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b}, {24'd0, e.fwd});
            check("stall_cnt", e.id, stall_cnt, e.sc);
            check("flush_cnt", e.id, flush_cnt, e.fc);
        end
    end

    task automatic cyc(
        input int              id,
        input bit              chk,
        input logic            rst,
        input logic [4:0]      rs,
        input logic [4:0]      rt,
        input logic            urs,
        input logic            urt,
        input logic [4:0]      rd,
        input logic            rw,
        input logic            mr,
        input logic            br,
        input logic            bt,
        input logic            jmp,
        input logic [3:0]      ectrl,
        input logic [7:0]      efwd
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        id_rs        = rs;
        id_rt        = rt;
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_branch    = br;
        branch_taken = bt;
        jump         = jmp;
        if (chk) begin
            e.id   = id;
            e.ctrl = ectrl;
            e.fwd  = efwd;
            e.sc   = c_PERF ? m_sc : '0;
            e.fc   = c_PERF ? m_fc : '0;
            sb.push_back(e);
        end
        if (rst) begin
            m_sc = '0;
            m_fc = '0;
        end else begin
            if (ectrl[1]) m_sc = m_sc + 1;
            if (ectrl[0]) m_fc = m_fc + 1;
        end
    endtask

    initial begin
        reset = 1'b1;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_branch = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        repeat (2) @(posedge clk);

        //   id  chk rst rs rt urs urt rd rw mr br bt jmp  ctrl     fwd
        cyc( 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1101, 8'h00); // reset: flush follows branch_taken
        cyc( 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);
        // lw $2 -> add $3,$2,$4
        cyc( 2, 1, 0, 1, 2, 1, 0, 2, 1, 1, 0, 0, 0, 4'b1100, 8'h00);
        cyc( 3, 1, 0, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 4'b0010, 8'h00);
        cyc( 4, 1, 0, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 4'b1100, 8'h00);
        cyc( 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h40);
        cyc( 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);
        cyc( 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);
        // add $5,$1,$1 -> beq $5,$0 (taken)
        cyc( 8, 1, 0, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 4'b1100, 8'h00);
        cyc( 9, 1, 0, 5, 0, 1, 1, 0, 0, 0, 1, 1, 0, 4'b0010, 8'h00);
        cyc(10, 1, 0, 5, 0, 1, 1, 0, 0, 0, 1, 1, 0, 4'b1101, 8'h08);
        cyc(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h40);
        cyc(12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);
        // lw $6 -> beq $6,$7 (taken): two stall cycles
        cyc(13, 1, 0, 1, 6, 1, 0, 6, 1, 1, 0, 0, 0, 4'b1100, 8'h00);
        cyc(14, 1, 0, 6, 7, 1, 1, 0, 0, 0, 1, 1, 0, 4'b0010, 8'h00);
        cyc(15, 1, 0, 6, 7, 1, 1, 0, 0, 0, 1, 1, 0, 4'b0010, 8'h00);
        cyc(16, 1, 0, 6, 7, 1, 1, 0, 0, 0, 1, 1, 0, 4'b1101, 8'h04);
        cyc(17, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);
        // add $8 -> sub $8 -> or $9,$8,$8: MEM beats WB
        cyc(18, 1, 0, 1, 1, 1, 1, 8, 1, 0, 0, 0, 0, 4'b1100, 8'h00);
        cyc(19, 1, 0, 2, 3, 1, 1, 8, 1, 0, 0, 0, 0, 4'b1100, 8'h00);
        cyc(20, 1, 0, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 4'b1100, 8'h0A);
        cyc(21, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'hA0);
        cyc(22, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);
        // writes to $0 never stall or forward; jump flushes
        cyc(23, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b1100, 8'h00);
        cyc(24, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 4'b1100, 8'h00);
        cyc(25, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 4'b1101, 8'h00);
        cyc(26, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 4'b1100, 8'h00);
        cyc(27, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);
        cyc(28, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);
        // reset asserted during a load-use stall
        cyc(29, 1, 0, 3, 2, 1, 0, 2, 1, 1, 0, 0, 0, 4'b1100, 8'h00);
        cyc(30, 0, 1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 4'b0010, 8'h00);
        cyc(31, 1, 0, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 4'b1100, 8'h00);
        cyc(32, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It replaces the separate load-use detector and EX forwarding unit. It keeps its own registered shadow of the destination and source fields of the instructions in EX, MEM and WB. It adds ID-stage forwarding so the branch comparator and regfile reads see in-flight results, branch-dependency stalls, and optional stall/flush counters.

## Interface
- REG_AW, 5, register-index width; the register count is 2**REG_AW and register 0 is hard-wired zero.
- CNT_W, 32, width of the performance counters.
- clk input 1: pipeline clock; all state updates on the rising edge.
- reset input 1: synchronous, active-high; clears all state.
- id_rs, id_rt input REG_AW each: source fields of the instruction in ID.
- id_use_rs, id_use_rt input 1 each: the ID instruction actually reads rs / rt.
- id_rd input REG_AW: destination already muxed by RegDest.
- id_reg_write, id_mem_read, id_branch input 1 each: raw control-unit outputs for ID.
- branch_taken, jump input 1 each: ID-stage branch-resolved and jump flags.
- pc_write output 1: 0 holds the PC.
- if_id_write output 1: 0 holds IF/ID.
- nop_mux output 1: 1 zeroes the control bits entering ID/EX.
- if_flush output 1: clears IF/ID.
- fwd_ex_a, fwd_ex_b output 2 each: EX ALU operand selects. 00 = ID/EX data, 10 = EX/MEM ALU result, 01 = WB write data.
- fwd_id_a, fwd_id_b output 2 each: ID operand selects (regfile rs/rt). Same encoding, with 10 = EX/MEM ALU result.
- stall_cnt, flush_cnt output CNT_W each: performance counters.

## Operation
- Shadow stages EX, MEM and WB each hold {we, ld, rd, rs, rt}.
- Every cycle, with no enable: WB<=MEM and MEM<=EX.
- EX<={id_reg_write, id_mem_read, id_rd, id_rs, id_rt} when stall=0.
- EX<=bubble (we=0, ld=0, fields 0) when stall=1.
- A source match requires the source to be used, the stage's we=1, rd!=0, and rd equal to the source.
- stall = load_use | br_alu | br_load.
  - load_use: EX.ld and a match with EX.
  - br_alu: id_branch and a match with EX, where EX.ld=0.
  - br_load: id_branch and a match with MEM, where MEM.ld=1.
- Consequences:
  - A branch behind a load stalls 2 cycles.
  - A branch behind an ALU op stalls 1 cycle.
  - A non-branch behind a load stalls 1 cycle.
- pc_write = if_id_write = ~stall; nop_mux = stall.
- if_flush = (branch_taken | jump) & ~stall. A stalled branch never flushes; it resolves on the cycle its operands are forwardable.
- fwd_ex_x:
  - 10 if MEM matches EX.x, with MEM.ld=0.
  - Else 01 if WB matches.
  - Else 00.
  - MEM has priority over WB.
  - A load in MEM never yields 10; the stall guarantees it has reached WB.
- fwd_id_x:
  - 10 if MEM matches id_x, with MEM.ld=0.
  - Else 01 if WB matches (write-through bypass).
  - Else 00.
- A rd=0 producer never forwards and never stalls.
- Simultaneous stall and branch_taken: the stall wins and the flush is deferred.

## Timing
- All control and forward outputs are combinational from the shadow registers and the ID inputs; there are no added pipeline cycles.
- The EX shadow mirrors ID/EX: a value captured at edge n is used by fwd_ex in cycle n+1.
- Reset values:
  - Shadow all bubble.
  - pc_write=1, if_id_write=1, nop_mux=0.
  - if_flush = (branch_taken|jump).
  - All fwd=00; counters 0.
- Reset takes effect mid-stall: the cycle after reset, stall=0 regardless of prior EX contents.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with if_flush=1.
  - Both saturate at all-ones and clear on reset.
- HAZARD_PERF_EN undefined: no counter registers are built; stall_cnt and flush_cnt are driven constant 0.

## Test plan
- lw $2 → add $3,$2,$4 → exactly 1 stall cycle (pc_write=0, nop_mux=1). Next cycle fwd_ex_a=01.
- add $5,$1,$1 → beq $5,$0 → 1 stall cycle. Next cycle fwd_id_a=10, then if_flush=1 if taken.
- lw $6 → beq $6,$7 → 2 stall cycles, then fwd_id_a=01. flush_cnt increments by 1 and stall_cnt by 2.
- add $8 → sub $8 → or $9,$8,$8 → fwd_ex_a=fwd_ex_b=10 (MEM beats WB).
- Writes to $0 followed by a use of $0 → no stall, all fwd=00.
- Assert reset during a load-use stall → next cycle pc_write=1 and counters 0. Without HAZARD_PERF_EN, counters read 0 throughout.
